// File: rtl/pulse_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sched_pkg
// Purpose  : Shared types and parameter defaults for the pulse scheduler.
//            Holds the FSM state encoding and the default widths used by
//            pulse_sched and rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_sched_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : pulse_sched_pkg
`default_nettype wire

// File: rtl/pulse_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin selector. The search starts at the
//            channel after i_ptr and wraps from NUM_CH-1 back to 0.
// Ports    : i_req   - request vector, one bit per channel
//            i_ptr   - index of the most recently granted channel
//            o_grant - one-hot winner (zero when no request)
//            o_idx   - index of the winner
//            o_valid - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  output logic [NUM_CH-1:0]         o_grant,
  output logic [$clog2(NUM_CH)-1:0] o_idx,
  output logic                      o_valid
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] w_cand;

  // Walk the channels in priority order ptr+1 .. ptr+NUM_CH (mod NUM_CH);
  // the first requester found wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % NUM_CH);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/pulse_sched.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sched
// Purpose  : Shared pulse timer. Channels request bursts; a round-robin
//            arbiter picks an owner, whose interval and burst length are
//            latched. The timer then emits burst_len one-cycle pulses spaced
//            'interval' cycles apart and signals completion with done.
// Ports    : clk, reset_n (async, active-low)
//            req[NUM_CH]       - level burst requests
//            interval[CNT_W]   - cycles between pulses (0 treated as 1)
//            burst_len[LEN_W]  - pulses per burst
//            hold              - freezes the interval counter
//            abort             - cancels the active burst
//            grant[NUM_CH]     - one-hot timer owner, zero when idle
//            busy              - FSM not in IDLE
//            pulse_out         - registered one-cycle pulse
//            done, done_ch     - burst completion pulse and owner index
// Revision : 1.0 - initial release
// ============================================================================
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         req,
  input  logic [CNT_W-1:0]          interval,
  input  logic [LEN_W-1:0]          burst_len,
  input  logic                      hold,
  input  logic                      abort,
  output logic [NUM_CH-1:0]         grant,
  output logic                      busy,
  output logic                      pulse_out,
  output logic                      done,
  output logic [$clog2(NUM_CH)-1:0] done_ch
);

  localparam int IDX_W = $clog2(NUM_CH);

  state_t            r_state;
  logic [NUM_CH-1:0] r_grant;
  logic [IDX_W-1:0]  r_ptr;       // last granted channel, also the owner
  logic [CNT_W-1:0]  r_interval;
  logic [CNT_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_rem;
  logic              r_pulse;
  logic              r_done;
  logic [IDX_W-1:0]  r_done_ch;

  logic [NUM_CH-1:0] w_arb_grant;
  logic [IDX_W-1:0]  w_arb_idx;
  logic              w_arb_valid;
  logic [CNT_W-1:0]  w_cnt_last;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Terminal count of the interval counter; r_interval is never 0.
  assign w_cnt_last = r_interval - CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ptr      <= IDX_W'(NUM_CH - 1);
      r_interval <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_rem      <= '0;
      r_pulse    <= 1'b0;
      r_done     <= 1'b0;
      r_done_ch  <= '0;
    end else begin
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      // Abort outranks hold and terminal count in every non-idle state.
      if (abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
        r_grant <= '0;
        r_cnt   <= '0;
        r_rem   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_arb_valid) begin
              r_state    <= ST_LOAD;
              r_grant    <= w_arb_grant;
              r_ptr      <= w_arb_idx;
              r_interval <= (interval == '0) ? CNT_W'(1) : interval;
              r_len      <= burst_len;
            end
          end
          ST_LOAD: begin
            r_cnt   <= '0;
            r_rem   <= r_len;
            r_state <= (r_len == '0) ? ST_DONE : ST_RUN;
          end
          ST_RUN: begin
            if (!hold) begin
              if (r_cnt == w_cnt_last) begin
                r_pulse <= 1'b1;
                r_cnt   <= '0;
                r_rem   <= r_rem - LEN_W'(1);
                if (r_rem == LEN_W'(1)) begin
                  r_state <= ST_DONE;
                end
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_DONE: begin
            r_done    <= 1'b1;
            r_done_ch <= r_ptr;
            r_grant   <= '0;
            r_state   <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        endcase
      end
    end
  end

  assign grant     = r_grant;
  assign busy      = (r_state != ST_IDLE);
  assign pulse_out = r_pulse;
  assign done      = r_done;
  assign done_ch   = r_done_ch;

endmodule : pulse_sched
`default_nettype wire

// File: tb/tb_pulse_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_sched
// Purpose  : Directed self-checking bench for pulse_sched (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_sched;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [7:0] interval;
  logic [3:0] burst_len;
  logic       hold;
  logic       abort;
  logic [3:0] grant;
  logic       busy;
  logic       pulse_out;
  logic       done;
  logic [1:0] done_ch;

  int n_vec;
  int n_err;
  int n_pulse;

  pulse_sched u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .interval  (interval),
    .burst_len (burst_len),
    .hold      (hold),
    .abort     (abort),
    .grant     (grant),
    .busy      (busy),
    .pulse_out (pulse_out),
    .done      (done),
    .done_ch   (done_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_vec++;
    if (obs !== expd) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expd);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_pulse"}, 32'(pulse_out), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic       exp_p;
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; req = '0; interval = '0; burst_len = '0;
    hold = 1'b0; abort = 1'b0;

    // ---------------- reset values ----------------
    #2;
    chk_idle("rst");
    chk("rst_done_ch", 32'(done_ch), 32'h0);
    #10 reset_n = 1'b1;
    tick();

    // ---------------- idle with no requests ----------------
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("noreq");
    end

    // ---------------- basic burst: ch1, interval 3, len 2 ----------------
    req = 4'b0010; interval = 8'd3; burst_len = 4'd2;
    tick();                                   // edge 1
    chk("b_grant", 32'(grant), 32'h2);
    chk("b_busy", 32'(busy), 32'h1);
    req = '0;
    for (int e = 2; e <= 9; e++) begin
      tick();
      chk("b_pulse", 32'(pulse_out), 32'((e == 5) || (e == 8)));
      chk("b_done", 32'(done), 32'(e == 9));
    end
    chk("b_done_ch", 32'(done_ch), 32'h1);
    chk("b_busy_end", 32'(busy), 32'h0);
    chk("b_grant_end", 32'(grant), 32'h0);

    // ---------------- round-robin after fresh reset ----------------
    tick();
    reset_n = 1'b0;
    #2;
    chk_idle("rst2");
    reset_n = 1'b1;
    req = 4'hF; interval = 8'd1; burst_len = 4'd1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      chk("rr_grant", 32'(grant), 32'(exp_g));
      tick();
      tick();
      chk("rr_pulse", 32'(pulse_out), 32'h1);
      if (k == 4) req = '0;
      tick();
      chk("rr_done", 32'(done), 32'h1);
      chk("rr_done_ch", 32'(done_ch), 32'(k % 4));
    end

    // ---------------- hold stretches spacing: interval 4, len 3 ----------------
    req = 4'b0001; interval = 8'd4; burst_len = 4'd3;
    tick();                                   // edge 1
    chk("h_grant", 32'(grant), 32'h1);
    req = '0;
    n_pulse = 0;
    for (int e = 2; e <= 25; e++) begin
      hold = ((e >= 8) && (e <= 12)) || ((e >= 17) && (e <= 21));
      tick();
      exp_p = (e == 6) || (e == 15) || (e == 24);
      chk("h_pulse", 32'(pulse_out), 32'(exp_p));
      if (pulse_out) n_pulse++;
      chk("h_done", 32'(done), 32'(e == 25));
    end
    hold = 1'b0;
    chk("h_npulse", 32'(n_pulse), 32'd3);

    // ---------------- abort after first pulse ----------------
    req = 4'b0100; interval = 8'd2; burst_len = 4'd4;
    tick();
    chk("a_grant", 32'(grant), 32'h4);
    req = '0;
    tick(); tick(); tick();
    chk("a_pulse1", 32'(pulse_out), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("a_abort");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("a_nopulse", 32'(pulse_out), 32'h0);
      chk("a_nodone", 32'(done), 32'h0);
    end
    req = 4'hF;
    tick();
    chk("a_next", 32'(grant), 32'h8);
    req = '0;
    abort = 1'b1;                             // abort while in LOAD
    tick();
    abort = 1'b0;
    chk_idle("a_load");

    // ---------------- interval 0; abort ignored in IDLE ----------------
    req = 4'b0001; interval = 8'd0; burst_len = 4'd3; abort = 1'b1;
    tick();
    chk("z_grant", 32'(grant), 32'h1);
    chk("z_busy", 32'(busy), 32'h1);
    req = '0; abort = 1'b0;
    for (int e = 2; e <= 6; e++) begin
      tick();
      chk("z_pulse", 32'(pulse_out), 32'((e >= 3) && (e <= 5)));
      chk("z_done", 32'(done), 32'(e == 6));
    end
    chk("z_done_ch", 32'(done_ch), 32'h0);

    // ---------------- burst_len 0 ----------------
    req = 4'b0010; interval = 8'd5; burst_len = 4'd0;
    tick();
    chk("l0_grant", 32'(grant), 32'h2);
    req = '0;
    tick();
    chk("l0_pulse_a", 32'(pulse_out), 32'h0);
    chk("l0_done_a", 32'(done), 32'h0);
    tick();
    chk("l0_pulse_b", 32'(pulse_out), 32'h0);
    chk("l0_done", 32'(done), 32'h1);
    chk("l0_done_ch", 32'(done_ch), 32'h1);
    chk("l0_busy", 32'(busy), 32'h0);

    // ---------------- reset mid-burst ----------------
    req = 4'b0100; interval = 8'd2; burst_len = 4'd4;
    tick();
    req = '0;
    tick(); tick(); tick();
    chk("r_pulse_pre", 32'(pulse_out), 32'h1);
    reset_n = 1'b0;
    #1;
    chk_idle("r_async");
    #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_idle("r_after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pulse_sched
`default_nettype wire

// File: doc/pulse_sched.md
PULSE_SCHED -- requirements
Module: pulse_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting channels (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of interval counter.
REQ-003 SHALL have parameter LEN_W, default 4, width of burst length.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port req  input  NUM_CH  level burst requests, one bit per channel.
REQ-007 SHALL have port interval  input  CNT_W  cycles between pulses, latched at grant.
REQ-008 SHALL have port burst_len  input  LEN_W  pulses per burst, latched at grant.
REQ-009 SHALL have port hold  input  1  freezes the interval counter while high.
REQ-010 SHALL have port abort  input  1  synchronous cancel of the active burst.
REQ-011 SHALL have port grant  output  NUM_CH  one-hot owner of the timer; zero when idle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port pulse_out  output  1  registered one-cycle pulse.
REQ-014 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-015 SHALL have port done_ch  output  $clog2(NUM_CH)  channel index that completed; valid with done.

Function
REQ-016 SHALL implement FSM IDLE, LOAD, RUN, DONE.
REQ-017 IDLE: req != 0 at an edge -> LOAD; grant set one-hot to arbiter winner, interval and burst_len latched on that edge.
REQ-018 Arbitration SHALL be round-robin: search starts at last-granted+1, wraps at NUM_CH-1 to 0; req sampled only in IDLE.
REQ-019 LOAD -> RUN on the next edge; counter cleared to 0, remaining = latched burst_len; latched burst_len 0 -> DONE instead (no pulse).
REQ-020 Latched interval 0 SHALL be treated as 1 (pulse every RUN cycle).
REQ-021 RUN, hold=0: counter == interval-1 -> pulse_out<=1, counter<=0, remaining--; else pulse_out<=0, counter++.
REQ-022 RUN, hold=1: counter and remaining frozen, pulse_out<=0.
REQ-023 Pulse decrementing remaining to 0 -> state DONE on the same edge.
REQ-024 DONE: next edge done<=1, done_ch<=owner index, grant<=0, state<=IDLE; pulse_out<=0.
REQ-025 abort=1 in LOAD/RUN/DONE: next edge state IDLE, grant 0, pulse_out 0, done stays 0; abort has priority over hold and terminal count.
REQ-026 abort in IDLE SHALL be ignored; req deasserted mid-burst SHALL NOT stop the burst.
REQ-027 Round-robin pointer SHALL update at grant, including aborted grants.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, grant 0, busy 0, pulse_out 0, done 0, done_ch 0, counter 0, remaining 0.
REQ-029 Pointer reset value SHALL be NUM_CH-1 so channel 0 has first priority.
REQ-030 Reset asserted mid-burst SHALL discard the burst with no done.

Structure
REQ-031 State encoding enum and parameter defaults SHALL live in package pulse_sched_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (req, pointer -> one-hot grant, index).

Verification
REQ-033 Reset release, req=0 for 10 cycles -> grant 0, busy 0, pulse_out 0 throughout.
REQ-034 req=0010, interval=3, burst_len=2, held edge 1 -> grant=0010 after edge 1, pulse_out high after edges 5 and 8, done=1 with done_ch=1 after edge 9, busy 0 after edge 9.
REQ-035 req=1111 continuous, burst_len=1, interval=1 -> grants in order ch0, ch1, ch2, ch3, ch0.
REQ-036 Burst interval=4, burst_len=3, hold high 5 cycles between pulses -> pulse spacing grows by exactly 5 cycles, 3 pulses total.
REQ-037 abort pulsed after first pulse of burst_len=4 -> IDLE next edge, no further pulses, done never asserts, next grant goes to following channel.
REQ-038 burst_len=0 and interval=0 cases -> burst_len 0 gives done with no pulse; interval 0 gives pulses on consecutive cycles.
